l2c_fill_wr: RTL and testbench

//   Fill write-data stage of the L2C fill path, downstream of the fill tag FSM. When the tag FSM holds a

---
 rtl/l2c_fill_wr.sv | 117 +++++++++++
 tb/tb_l2c_fill_wr.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2c_fill_wr.sv
// Fill write-data stage of the L2C fill path: wins the L2 data SRAM write port for the tag FSM,
// grants it with o_fill_start, then streams one line of MNI fill beats into the SRAM with byte parity.
module l2c_fill_wr #(
   parameter int DW    = 64,
   parameter int BEATS = 8,
   parameter int AW    = 18
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              i_fill_sram_req,
   input  logic [AW-1:0]     i_fill_sram_adr,
   output logic              o_fill_start,
   output logic              o_fill_end,
   input  logic              i_mni_fill_data_valid,
   input  logic [DW-1:0]     i_mni_fill_data,
   input  logic [DW/8-1:0]   i_mni_fill_be,
   output logic              o_sram_req,
   input  logic              i_sram_gnt,
   output logic              o_sram_we,
   output logic [AW-1:0]     o_sram_adr,
   output logic [DW-1:0]     o_sram_wdata,
   output logic [DW/8-1:0]   o_sram_be,
   output logic [DW/8-1:0]   o_sram_par,
   output logic              o_busy,
   output logic              o_err
);

   localparam int NB  = DW / 8;
   localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BSH = (NB > 1) ? $clog2(NB) : 0;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   base;
   logic            fill_start;
   logic            accept;
   logic            last_beat;
   logic            bad_beat;
   logic            bad_gnt;
   logic [AW-1:0]   beat_adr;
   logic [NB-1:0]   beat_par;

   // A beat is taken in XFER, or in the grant cycle itself so the first beat can ride with o_fill_start.
   always_comb begin
      fill_start = (state == REQ) && i_sram_gnt && i_fill_sram_req;
      accept     = i_mni_fill_data_valid && ((state == XFER) || fill_start);
      last_beat  = accept && (cnt == LAST);
      bad_beat   = i_mni_fill_data_valid &&
                   ((state == IDLE) || (state == DRAIN) || ((state == REQ) && !fill_start));
      bad_gnt    = !i_sram_gnt && ((state == XFER) || (state == DRAIN));
      beat_adr   = base + (AW'(cnt) << BSH);
      for (int i = 0; i < NB; i++) begin
         beat_par[i] = ^i_mni_fill_data[8*i +: 8];
      end
   end

   assign o_fill_start = fill_start;
   assign o_fill_end   = last_beat;
   assign o_sram_req   = (state != IDLE);
   assign o_busy       = (state != IDLE);

   // Sequencer plus one-stage write pipe; a reset mid-line simply abandons the partial line.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         base         <= '0;
         o_sram_we    <= 1'b0;
         o_sram_adr   <= '0;
         o_sram_wdata <= '0;
         o_sram_be    <= '0;
         o_sram_par   <= '0;
         o_err        <= 1'b0;
      end else begin
         o_sram_we <= accept;
         if (accept) begin
            o_sram_adr   <= beat_adr;
            o_sram_wdata <= i_mni_fill_data;
            o_sram_be    <= i_mni_fill_be;
            o_sram_par   <= beat_par;
            cnt          <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end
         if (bad_beat || bad_gnt) begin
            o_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (i_fill_sram_req) begin
                  state <= REQ;
                  base  <= i_fill_sram_adr;
                  cnt   <= '0;
               end
            end
            REQ: begin
               if (fill_start) begin
                  state <= last_beat ? DRAIN : XFER;
               end
            end
            XFER: begin
               if (last_beat) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2c_fill_wr.sv
// Directed bench for l2c_fill_wr: full line, delayed grant, gappy beats, parity, reset mid-line, errors.
module tb_l2c_fill_wr;

   localparam int DW    = 64;
   localparam int BEATS = 8;
   localparam int AW    = 18;
   localparam int NB    = DW / 8;

   logic              Clk;
   logic              Reset_n;
   logic              i_fill_sram_req;
   logic [AW-1:0]     i_fill_sram_adr;
   logic              o_fill_start;
   logic              o_fill_end;
   logic              i_mni_fill_data_valid;
   logic [DW-1:0]     i_mni_fill_data;
   logic [NB-1:0]     i_mni_fill_be;
   logic              o_sram_req;
   logic              i_sram_gnt;
   logic              o_sram_we;
   logic [AW-1:0]     o_sram_adr;
   logic [DW-1:0]     o_sram_wdata;
   logic [NB-1:0]     o_sram_be;
   logic [NB-1:0]     o_sram_par;
   logic              o_busy;
   logic              o_err;

   int n_checks;
   int n_fail;

   l2c_fill_wr #(.DW(DW), .BEATS(BEATS), .AW(AW)) dut (
      .Clk                   (Clk),
      .Reset_n               (Reset_n),
      .i_fill_sram_req       (i_fill_sram_req),
      .i_fill_sram_adr       (i_fill_sram_adr),
      .o_fill_start          (o_fill_start),
      .o_fill_end            (o_fill_end),
      .i_mni_fill_data_valid (i_mni_fill_data_valid),
      .i_mni_fill_data       (i_mni_fill_data),
      .i_mni_fill_be         (i_mni_fill_be),
      .o_sram_req            (o_sram_req),
      .i_sram_gnt            (i_sram_gnt),
      .o_sram_we             (o_sram_we),
      .o_sram_adr            (o_sram_adr),
      .o_sram_wdata          (o_sram_wdata),
      .o_sram_be             (o_sram_be),
      .o_sram_par            (o_sram_par),
      .o_busy                (o_busy),
      .o_err                 (o_err)
   );

   // 10-time-unit clock; inputs change just after the falling edge.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic drive(input logic req, input logic gnt, input logic valid,
                        input logic [DW-1:0] data, input logic [NB-1:0] be);
      @(negedge Clk);
      i_fill_sram_req       = req;
      i_sram_gnt            = gnt;
      i_mni_fill_data_valid = valid;
      i_mni_fill_data       = data;
      i_mni_fill_be         = be;
      #1;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Asynchronous reset must clear every output before any clock edge.
   task automatic test_reset();
      i_fill_sram_req = 1'b0; i_fill_sram_adr = '0; i_mni_fill_data_valid = 1'b0;
      i_mni_fill_data = '0; i_mni_fill_be = '0; i_sram_gnt = 1'b0;
      Reset_n = 1'b1;
      #1;
      Reset_n = 1'b0;
      #1;
      n_checks++;
      if ({o_fill_start, o_fill_end, o_sram_req, o_sram_we, o_busy, o_err} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got %b required 000000",
                  {o_fill_start, o_fill_end, o_sram_req, o_sram_we, o_busy, o_err});
      end
      n_checks++;
      if (o_sram_adr !== '0 || o_sram_wdata !== '0 || o_sram_be !== '0 || o_sram_par !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_data: got adr %h data %h be %h par %h required all 0",
                  o_sram_adr, o_sram_wdata, o_sram_be, o_sram_par);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      tick();
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_idle: got busy %b required 0", o_busy);
      end
   endtask

   // Grant with the request, 8 beats back to back starting on the fill_start cycle.
   task automatic test_full_line();
      logic [AW-1:0] base;
      logic [AW-1:0] exp_adr;
      logic [DW-1:0] d;
      logic          exp_start;
      logic          exp_end;
      base = 18'h00A40;
      i_fill_sram_adr = base;
      drive(1'b1, 1'b1, 1'b0, '0, '0);
      tick();
      n_checks++;
      if (o_sram_req !== 1'b1 || o_busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL full_req: got req %b busy %b required 1 1", o_sram_req, o_busy);
      end
      for (int k = 0; k < BEATS; k++) begin
         d = 64'hA5A5_0000_0000_0000 | 64'(k);
         drive(k == 0, 1'b1, 1'b1, d, 8'hFF);
         exp_start = (k == 0);
         exp_end   = (k == BEATS - 1);
         n_checks++;
         if (o_fill_start !== exp_start || o_fill_end !== exp_end) begin
            n_fail++;
            $display("[TB] FAIL full_handshake beat %0d: got start %b end %b required %b %b",
                     k, o_fill_start, o_fill_end, exp_start, exp_end);
         end
         tick();
         exp_adr = base + AW'(8 * k);
         n_checks++;
         if (o_sram_we !== 1'b1 || o_sram_adr !== exp_adr || o_sram_wdata !== d) begin
            n_fail++;
            $display("[TB] FAIL full_write beat %0d: got we %b adr %h data %h required 1 %h %h",
                     k, o_sram_we, o_sram_adr, o_sram_wdata, exp_adr, d);
         end
      end
      n_checks++;
      if (o_sram_req !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL full_drain_req: got %b required 1", o_sram_req);
      end
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      tick();
      n_checks++;
      if (o_sram_req !== 1'b0 || o_sram_we !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL full_idle: got req %b we %b busy %b err %b required 0 0 0 0",
                  o_sram_req, o_sram_we, o_busy, o_err);
      end
   endtask

   // Grant held off for 5 cycles; fill_start only on the grant cycle, beats begin one cycle later.
   task automatic test_delayed_grant();
      logic [AW-1:0] base;
      logic [AW-1:0] exp_adr;
      logic [DW-1:0] d;
      logic          exp_end;
      base = 18'h1F3C0;
      i_fill_sram_adr = base;
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, '0, '0);
         n_checks++;
         if (o_fill_start !== 1'b0 || o_sram_req !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL dgnt_wait %0d: got start %b req %b required 0 1",
                     i, o_fill_start, o_sram_req);
         end
         tick();
         n_checks++;
         if (o_sram_we !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL dgnt_nowrite %0d: got we %b required 0", i, o_sram_we);
         end
      end
      drive(1'b1, 1'b1, 1'b0, '0, '0);
      n_checks++;
      if (o_fill_start !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL dgnt_start: got %b required 1", o_fill_start);
      end
      tick();
      for (int k = 0; k < BEATS; k++) begin
         d = 64'h5EED_0000_1111_0000 | 64'(k);
         drive(1'b0, 1'b1, 1'b1, d, 8'h0F);
         exp_end = (k == BEATS - 1);
         n_checks++;
         if (o_fill_start !== 1'b0 || o_fill_end !== exp_end) begin
            n_fail++;
            $display("[TB] FAIL dgnt_handshake beat %0d: got start %b end %b required 0 %b",
                     k, o_fill_start, o_fill_end, exp_end);
         end
         tick();
         exp_adr = base + AW'(8 * k);
         n_checks++;
         if (o_sram_we !== 1'b1 || o_sram_adr !== exp_adr || o_sram_be !== 8'h0F) begin
            n_fail++;
            $display("[TB] FAIL dgnt_write beat %0d: got we %b adr %h be %h required 1 %h 0f",
                     k, o_sram_we, o_sram_adr, o_sram_be, exp_adr);
         end
      end
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      tick();
      n_checks++;
      if (o_busy !== 1'b0 || o_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL dgnt_idle: got busy %b err %b required 0 0", o_busy, o_err);
      end
   endtask

   // Valid pattern 1,0,0,1,1,0,1,1,1,1,1 from the fill_start cycle: 8 contiguous writes, no error.
   task automatic test_gappy();
      logic [AW-1:0] base;
      logic [AW-1:0] exp_adr;
      logic [10:0]   pat;
      logic [DW-1:0] d;
      logic          v;
      logic          exp_end;
      int            k;
      base = 18'h02000;
      pat  = 11'b11111011001;
      k    = 0;
      i_fill_sram_adr = base;
      drive(1'b1, 1'b1, 1'b0, '0, '0);
      tick();
      for (int j = 0; j < 11; j++) begin
         v = pat[j];
         d = 64'h0BAD_F00D_0000_0000 | 64'(j);
         drive(j == 0, 1'b1, v, d, 8'hFF);
         exp_end = v && (k == BEATS - 1);
         n_checks++;
         if (o_fill_end !== exp_end) begin
            n_fail++;
            $display("[TB] FAIL gap_end slot %0d: got %b required %b", j, o_fill_end, exp_end);
         end
         tick();
         exp_adr = base + AW'(8 * k);
         n_checks++;
         if (o_sram_we !== v || (v && (o_sram_adr !== exp_adr || o_sram_wdata !== d))) begin
            n_fail++;
            $display("[TB] FAIL gap_write slot %0d: got we %b adr %h data %h required %b %h %h",
                     j, o_sram_we, o_sram_adr, o_sram_wdata, v, exp_adr, d);
         end
         if (v) k++;
      end
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      tick();
      n_checks++;
      if (o_err !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL gap_final: got err %b busy %b required 0 0", o_err, o_busy);
      end
   endtask

   // Hand-computed even parity per byte and byte-enable pass-through.
   task automatic test_parity();
      logic [DW-1:0] pd [8];
      logic [NB-1:0] pb [8];
      logic [NB-1:0] pp [8];
      logic [AW-1:0] base;
      pd[0] = 64'h0102_0304_0506_0708; pb[0] = 8'hA5; pp[0] = 8'hD3;
      pd[1] = 64'h0000_0000_0000_0000; pb[1] = 8'hFF; pp[1] = 8'h00;
      pd[2] = 64'h0101_0101_0101_0101; pb[2] = 8'h01; pp[2] = 8'hFF;
      pd[3] = 64'hFFFF_FFFF_FFFF_FFFF; pb[3] = 8'h80; pp[3] = 8'h00;
      pd[4] = 64'h0000_0000_0000_00FE; pb[4] = 8'h3C; pp[4] = 8'h01;
      pd[5] = 64'h8000_0000_0000_0000; pb[5] = 8'h00; pp[5] = 8'h80;
      pd[6] = 64'h0300_0000_0000_0001; pb[6] = 8'h5A; pp[6] = 8'h01;
      pd[7] = 64'h7F00_0000_0000_0000; pb[7] = 8'hC3; pp[7] = 8'h80;
      base = 18'h3FE00;
      i_fill_sram_adr = base;
      drive(1'b1, 1'b1, 1'b0, '0, '0);
      tick();
      for (int k = 0; k < BEATS; k++) begin
         drive(k == 0, 1'b1, 1'b1, pd[k], pb[k]);
         tick();
         n_checks++;
         if (o_sram_we !== 1'b1 || o_sram_par !== pp[k] || o_sram_be !== pb[k] ||
             o_sram_wdata !== pd[k]) begin
            n_fail++;
            $display("[TB] FAIL par_be beat %0d: got we %b par %h be %h data %h required 1 %h %h %h",
                     k, o_sram_we, o_sram_par, o_sram_be, o_sram_wdata, pp[k], pb[k], pd[k]);
         end
      end
      n_checks++;
      if (o_sram_adr !== 18'h3FE38) begin
         n_fail++;
         $display("[TB] FAIL par_last_adr: got %h required 3fe38", o_sram_adr);
      end
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      tick();
   endtask

   // Reset after beat 3 abandons the line; a fresh request then completes.
   task automatic test_reset_midline();
      logic [AW-1:0] base;
      logic [AW-1:0] exp_adr;
      logic          exp_end;
      i_fill_sram_adr = 18'h00100;
      drive(1'b1, 1'b1, 1'b0, '0, '0);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(k == 0, 1'b1, 1'b1, 64'h0000_0000_0000_0100 | 64'(k), 8'hFF);
         tick();
      end
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      Reset_n = 1'b0;
      #1;
      n_checks++;
      if ({o_fill_start, o_fill_end, o_sram_req, o_sram_we, o_busy, o_err} !== 6'b0 ||
          o_sram_adr !== '0 || o_sram_wdata !== '0 || o_sram_be !== '0 || o_sram_par !== '0) begin
         n_fail++;
         $display("[TB] FAIL midreset_outputs: got ctl %b adr %h data %h be %h par %h required all 0",
                  {o_fill_start, o_fill_end, o_sram_req, o_sram_we, o_busy, o_err},
                  o_sram_adr, o_sram_wdata, o_sram_be, o_sram_par);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      base = 18'h00240;
      i_fill_sram_adr = base;
      drive(1'b1, 1'b1, 1'b0, '0, '0);
      n_checks++;
      if (o_fill_end !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_idle: got end %b busy %b required 0 0", o_fill_end, o_busy);
      end
      tick();
      drive(1'b1, 1'b1, 1'b0, '0, '0);
      tick();
      for (int k = 0; k < BEATS; k++) begin
         drive(1'b0, 1'b1, 1'b1, 64'h2400_0000_0000_0000 | 64'(k), 8'hFF);
         exp_end = (k == BEATS - 1);
         n_checks++;
         if (o_fill_end !== exp_end) begin
            n_fail++;
            $display("[TB] FAIL midreset_end beat %0d: got %b required %b", k, o_fill_end, exp_end);
         end
         tick();
         exp_adr = base + AW'(8 * k);
         n_checks++;
         if (o_sram_we !== 1'b1 || o_sram_adr !== exp_adr) begin
            n_fail++;
            $display("[TB] FAIL midreset_write beat %0d: got we %b adr %h required 1 %h",
                     k, o_sram_we, o_sram_adr, exp_adr);
         end
      end
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      tick();
   endtask

   // Stray beat in IDLE and a grant drop in XFER both raise the sticky error.
   task automatic test_protocol();
      logic [AW-1:0] base;
      n_checks++;
      if (o_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL proto_pre: got err %b required 0", o_err);
      end
      drive(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
      tick();
      n_checks++;
      if (o_sram_we !== 1'b0 || o_err !== 1'b1 || o_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL proto_idle_beat: got we %b err %b busy %b required 0 1 0",
                  o_sram_we, o_err, o_busy);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, '0, '0);
         tick();
      end
      n_checks++;
      if (o_err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL proto_sticky: got err %b required 1", o_err);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      n_checks++;
      if (o_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL proto_reset_clear: got err %b required 0", o_err);
      end
      base = 18'h00C00;
      i_fill_sram_adr = base;
      drive(1'b1, 1'b1, 1'b0, '0, '0);
      tick();
      drive(1'b1, 1'b1, 1'b1, 64'h0C00_0000_0000_0000, 8'hFF);
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'h0C00_0000_0000_0001, 8'hFF);
      tick();
      n_checks++;
      if (o_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL proto_clean_xfer: got err %b required 0", o_err);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      n_checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL proto_gnt_drop: got err %b busy %b required 1 1", o_err, o_busy);
      end
      for (int k = 2; k < BEATS; k++) begin
         drive(1'b0, 1'b1, 1'b1, 64'h0C00_0000_0000_0000 | 64'(k), 8'hFF);
         tick();
      end
      n_checks++;
      if (o_sram_we !== 1'b1 || o_sram_adr !== 18'h00C38 || o_busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL proto_finish: got we %b adr %h busy %b required 1 00c38 1",
                  o_sram_we, o_sram_adr, o_busy);
      end
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      tick();
      n_checks++;
      if (o_busy !== 1'b0 || o_err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL proto_final: got busy %b err %b required 0 1", o_busy, o_err);
      end
   endtask

   // Scenarios run in order; the error scenario goes last because o_err is sticky.
   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_full_line();
      test_delayed_grant();
      test_gappy();
      test_parity();
      test_reset_midline();
      test_protocol();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
